// File: rtl/spirit_level_pkg.sv
// Shared types for the spirit level bar-graph driver.
// FSM states, classification result and default geometry.
package spirit_level_pkg;

  typedef enum logic [1:0] {
    ACCUM,
    CALC,
    SEARCH,
    UPDATE
  } state_t;

  typedef enum logic [1:0] {
    CENTRE,
    BIN,
    OOR
  } cls_t;

  localparam int N_LEDS = 10;
  localparam int HALF   = N_LEDS / 2;

endpackage

// File: rtl/spirit_level_avg.sv
// Sample window accumulator with valid/ready intake.
// avg_valid marks the cycle after the window-closing accept.
module spirit_level_avg
  import spirit_level_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int AVG_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     accum_en,
  input  logic signed [DATA_W-1:0] data,
  input  logic                     data_valid,
  output logic                     data_ready,
  output logic                     win_done,
  output logic                     avg_valid,
  output logic signed [DATA_W-1:0] avg
);

  localparam int ACC_W = DATA_W + AVG_LOG2;
  localparam int CNT_W = AVG_LOG2 + 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((1 << AVG_LOG2) - 1);

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_sh;
  logic [CNT_W-1:0]        cnt;
  logic                    accept;

  assign data_ready = en && accum_en;
  assign accept     = data_valid && data_ready;
  assign win_done   = accept && (cnt == CNT_LAST);
  assign acc_sh     = acc >>> AVG_LOG2;
  assign avg        = acc_sh[DATA_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc       <= '0;
      cnt       <= '0;
      avg_valid <= 1'b0;
    end else begin
      avg_valid <= win_done;
      if (!en || avg_valid) begin
        acc <= '0;
        cnt <= '0;
      end else if (accept) begin
        acc <= acc + ACC_W'(data);
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/spirit_level_bar.sv
// Tilt bar-graph driver: averages samples, bins them with
// hysteresis and drives a one-hot / centre-pair LED pattern.
module spirit_level_bar
  import spirit_level_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int N_LEDS    = 10,
  parameter int BIN_W     = 50,
  parameter int CENTER_W  = 25,
  parameter int AVG_LOG2  = 2,
  parameter int HYST      = 5,
  parameter int BLINK_DIV = 12500000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic signed [DATA_W-1:0] data,
  input  logic                     data_valid,
  output logic                     data_ready,
  output logic [N_LEDS-1:0]        led_display,
  output logic                     out_of_range,
  output logic                     led_update
);

  localparam int H     = N_LEDS / 2;
  localparam int J_W   = $clog2(H);
  localparam int M_W   = DATA_W + 2;
  localparam int BLK_W = $clog2(BLINK_DIV + 1);
  localparam logic signed [M_W-1:0] BIN_S = M_W'(BIN_W);
  localparam logic signed [M_W-1:0] CEN_S = M_W'(CENTER_W);
  localparam logic [DATA_W:0] HYST_U = (DATA_W + 1)'(HYST);
  localparam logic [N_LEDS-1:0] ONE = N_LEDS'(1);

  state_t state, state_n;
  cls_t   cls_q, cls_n;

  logic signed [DATA_W-1:0] avg, avg_q, avg_n, committed;
  logic signed [M_W-1:0]    rem_q, rem_n, m_prime;
  logic signed [DATA_W:0]   avg_x, diff;
  logic [DATA_W:0]          mag, adiff;
  logic [J_W-1:0]           j_q, j_n;
  logic [N_LEDS-1:0]        pat, pattern_q;
  logic [BLK_W-1:0]         blk;
  logic sign_q, sign_n, first, oor_q, upd_q, phase;
  logic win_done, avg_valid, commit;

  spirit_level_avg #(
    .DATA_W  (DATA_W),
    .AVG_LOG2(AVG_LOG2)
  ) u_avg (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .accum_en  (state == ACCUM),
    .data      (data),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .win_done  (win_done),
    .avg_valid (avg_valid),
    .avg       (avg)
  );

  // Magnitude at DATA_W+1 bits keeps the most negative input exact
  assign avg_x   = {avg[DATA_W-1], avg};
  assign mag     = avg_x[DATA_W] ? (DATA_W + 1)'(-avg_x) : avg_x;
  assign m_prime = $signed({1'b0, mag}) - CEN_S;

  assign diff   = {avg_q[DATA_W-1], avg_q}
                - {committed[DATA_W-1], committed};
  assign adiff  = diff[DATA_W] ? (DATA_W + 1)'(-diff) : diff;
  assign commit = first || (adiff > HYST_U);

  always_comb begin
    state_n = state;
    avg_n   = avg_q;
    sign_n  = sign_q;
    rem_n   = rem_q;
    j_n     = j_q;
    cls_n   = cls_q;
    unique case (state)
      ACCUM: begin
        if (win_done) state_n = CALC;
      end
      CALC: begin
        if (avg_valid) begin
          avg_n  = avg;
          sign_n = avg[DATA_W-1];
          rem_n  = m_prime;
          j_n    = '0;
          if (m_prime[M_W-1]) begin
            cls_n   = CENTRE;
            state_n = UPDATE;
          end else begin
            state_n = SEARCH;
          end
        end else begin
          state_n = ACCUM;
        end
      end
      SEARCH: begin
        if (j_q == J_W'(H - 1)) begin
          cls_n   = OOR;
          state_n = UPDATE;
        end else if (rem_q < BIN_S) begin
          cls_n   = BIN;
          state_n = UPDATE;
        end else begin
          rem_n = rem_q - BIN_S;
          j_n   = j_q + J_W'(1);
        end
      end
      UPDATE: state_n = ACCUM;
      default: state_n = ACCUM;
    endcase
    if (!en) state_n = ACCUM;
  end

  always_comb begin
    pat = '0;
    unique case (cls_q)
      CENTRE: pat = (ONE << (H - 1)) | (ONE << H);
      BIN: begin
        if (sign_q) pat = ONE << (H - 2 - int'(j_q));
        else        pat = ONE << (H + 1 + int'(j_q));
      end
      OOR: pat = sign_q ? ONE : (ONE << (N_LEDS - 1));
      default: pat = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ACCUM;
      avg_q     <= '0;
      sign_q    <= 1'b0;
      rem_q     <= '0;
      j_q       <= '0;
      cls_q     <= CENTRE;
      committed <= '0;
      first     <= 1'b1;
      pattern_q <= '0;
      oor_q     <= 1'b0;
      upd_q     <= 1'b0;
      blk       <= '0;
      phase     <= 1'b0;
    end else begin
      state  <= state_n;
      avg_q  <= avg_n;
      sign_q <= sign_n;
      rem_q  <= rem_n;
      j_q    <= j_n;
      cls_q  <= cls_n;
      upd_q  <= 1'b0;
      if (state == UPDATE && commit) begin
        pattern_q <= pat;
        oor_q     <= (cls_q == OOR);
        committed <= avg_q;
        first     <= 1'b0;
        upd_q     <= 1'b1;
      end
      if (blk == BLK_W'(BLINK_DIV - 1)) begin
        blk   <= '0;
        phase <= ~phase;
      end else begin
        blk <= blk + BLK_W'(1);
      end
    end
  end

  assign led_display  = oor_q ? (pattern_q & {N_LEDS{phase}})
                              : pattern_q;
  assign out_of_range = oor_q;
  assign led_update   = upd_q;

endmodule
